text_scanout: RTL and testbench

TEXT_SCANOUT -- requirements
Module: text_scanout

---
 rtl/text_scanout.sv | 137 +++++++++++++
 tb/tb_text_scanout.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/text_scanout.sv
// Character-mapped monochrome text display scan-out: timing counters, char RAM/font ROM
// fetch pipeline, pixel serialiser and blinking block cursor. All outputs lag the counters by 3 clocks.
module text_scanout #(
    parameter int   H_ACTIVE     = 512,
    parameter int   H_FRONT      = 16,
    parameter int   H_SYNC       = 64,
    parameter int   H_BACK       = 48,
    parameter int   V_ACTIVE     = 256,
    parameter int   V_FRONT      = 4,
    parameter int   V_SYNC       = 4,
    parameter int   V_BACK       = 20,
    parameter logic SYNC_POL     = 1'b0,
    parameter int   BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] read_ad,
    input  logic [7:0]  read_data,
    output logic [10:0] font_ad,
    input  logic [7:0]  font_data,
    input  logic [10:0] cursor_ad,
    input  logic        cursor_en,
    output logic        pixel,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int BW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [9:0]    hc_q, hc_d;
    logic [8:0]    vc_q, vc_d;
    logic          h_wrap, v_wrap, active, hs_now, vs_now;

    logic [2:0]    hl1_q, hl2_q, hl3_q, vl1_q;
    logic          de1_q, de2_q, de3_q;
    logic          hs1_q, hs2_q, hs3_q;
    logic          vs1_q, vs2_q, vs3_q;
    logic          fs1_q, fs2_q, fs3_q;
    logic [10:0]   addr1_q, addr2_q;
    logic [10:0]   font_ad_q;
    logic          cur_hit_q;
    logic [7:0]    shift_q;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_q;
    logic          load, glyph_bit;

    assign h_wrap = (hc_q == 10'(H_TOTAL - 1));
    assign v_wrap = (vc_q == 9'(V_TOTAL - 1));
    assign active = (hc_q < 10'(H_ACTIVE)) && (vc_q < 9'(V_ACTIVE));
    assign hs_now = (hc_q >= 10'(HS_START)) && (hc_q < 10'(HS_START + H_SYNC));
    assign vs_now = (vc_q >= 9'(VS_START)) && (vc_q < 9'(VS_START + V_SYNC));

    always_comb begin
        hc_d = h_wrap ? '0 : hc_q + 10'd1;
        vc_d = vc_q;
        if (h_wrap) begin
            vc_d = v_wrap ? '0 : vc_q + 9'd1;
        end
    end

    assign read_ad = active ? {vc_q[7:3], hc_q[8:3]} : '0;
    assign font_ad = font_ad_q;

    // The first pixel of a cell comes straight off the ROM output; the shifter supplies the other seven.
    assign load      = (hl3_q == 3'd0);
    assign glyph_bit = load ? font_data[7] : shift_q[7];
    assign pixel     = de3_q & (glyph_bit ^ cur_hit_q);

    assign de          = de3_q;
    assign hsync       = hs3_q;
    assign vsync       = vs3_q;
    assign frame_start = fs3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q        <= '0;
            vc_q        <= '0;
            {hl1_q, hl2_q, hl3_q, vl1_q} <= '0;
            {de1_q, de2_q, de3_q} <= '0;
            {fs1_q, fs2_q, fs3_q} <= '0;
            {hs1_q, hs2_q, hs3_q} <= {3{~SYNC_POL}};
            {vs1_q, vs2_q, vs3_q} <= {3{~SYNC_POL}};
            addr1_q     <= '0;
            addr2_q     <= '0;
            font_ad_q   <= '0;
            cur_hit_q   <= 1'b0;
            shift_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;

            hl1_q   <= hc_q[2:0];
            vl1_q   <= vc_q[2:0];
            de1_q   <= active;
            hs1_q   <= hs_now ? SYNC_POL : ~SYNC_POL;
            vs1_q   <= vs_now ? SYNC_POL : ~SYNC_POL;
            fs1_q   <= (hc_q == '0) && (vc_q == '0);
            addr1_q <= read_ad;

            hl2_q     <= hl1_q;
            de2_q     <= de1_q;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            fs2_q     <= fs1_q;
            addr2_q   <= addr1_q;
            font_ad_q <= {read_data, vl1_q};

            hl3_q <= hl2_q;
            de3_q <= de2_q;
            hs3_q <= hs2_q;
            vs3_q <= vs2_q;
            fs3_q <= fs2_q;
            // Cursor decision is frozen for a whole cell so mid-cell input changes cannot glitch it.
            if (hl2_q == 3'd0) begin
                cur_hit_q <= cursor_en & blink_q & (addr2_q == cursor_ad);
            end

            shift_q <= load ? {font_data[6:0], 1'b0} : {shift_q[6:0], 1'b0};

            if (h_wrap && v_wrap) begin
                if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt_q <= '0;
                    blink_q     <= ~blink_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_text_scanout.sv
// Directed bench for text_scanout on a reduced raster (96x24 clocks, 8x2 character cells,
// 2-frame blink) with 1-clock-latency character RAM and font ROM models.
module tb_text_scanout;
    localparam int HA = 64, HF = 8, HS = 16, HB = 8, HT = HA + HF + HS + HB;
    localparam int VA = 16, VF = 2, VS = 2, VB = 4, VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] read_ad, font_ad, cursor_ad;
    logic [7:0]  read_data, font_data;
    logic        cursor_en;
    logic        pixel, de, hsync, vsync, frame_start;

    logic [7:0]  ram [0:2047];
    logic [7:0]  rom [0:2047];

    int n_cmp = 0;
    int n_bad = 0;
    int n     = 0;
    bit phase_a = 1'b0;
    int de_cnt = 0, hs_cnt = 0;
    int fs_n [0:1];
    int de_rise [0:1];
    int fs_seen = 0, rise_seen = 0;
    logic prev_de = 1'b0;
    logic [7:0] first_pat = 8'hA5;
    logic [4:0] cur_exp = 5'b01100;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        read_data <= ram[read_ad];
        font_data <= rom[font_ad];
    end

    text_scanout #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0), .BLINK_FRAMES(BL)
    ) dut (
        .clk(clk), .reset(reset),
        .read_ad(read_ad), .read_data(read_data),
        .font_ad(font_ad), .font_data(font_data),
        .cursor_ad(cursor_ad), .cursor_en(cursor_en),
        .pixel(pixel), .de(de), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic logic [10:0] addr_of(input int q);
        logic [9:0] h;
        logic [8:0] v;
        h = 10'(q % HT);
        v = 9'((q / HT) % VT);
        if (h < 10'(HA) && v < 9'(VA)) return {v[7:3], h[8:3]};
        return '0;
    endfunction

    // One cycle of checks at the current falling edge, then advance to the next one.
    task automatic tick();
        int p, f, q;
        logic [9:0] h;
        logic [8:0] v;
        logic e_de, e_hs, e_vs, e_fs, e_px;
        logic [10:0] a;
        logic [7:0] ch, g;
        logic [2:0] vq;
        p = n - 3;
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_px = 1'b0;
        if (p >= 0) begin
            h = 10'(p % HT);
            v = 9'((p / HT) % VT);
            f = p / FT;
            e_de = (h < 10'(HA)) && (v < 9'(VA));
            e_hs = !((h >= 10'(HA + HF)) && (h < 10'(HA + HF + HS)));
            e_vs = !((v >= 9'(VA + VF)) && (v < 9'(VA + VF + VS)));
            e_fs = (h == 10'd0) && (v == 9'd0);
            if (e_de) begin
                a = addr_of(p);
                ch = ram[a];
                g = rom[{ch, v[2:0]}];
                e_px = g[3'd7 - h[2:0]] ^ (cursor_en && (a == cursor_ad) && ((f / BL) % 2 == 1));
            end
        end
        check_val("de", de, e_de);
        check_val("hsync", hsync, e_hs);
        check_val("vsync", vsync, e_vs);
        check_val("frame_start", frame_start, e_fs);
        check_val("pixel", pixel, e_px);
        check_val("read_ad", read_ad, addr_of(n));
        if (n >= 2) begin
            q = n - 2;
            vq = 3'((q / HT) % VT);
            check_val("font_ad", font_ad, {ram[addr_of(q)], vq});
        end
        if (n == 3) check_val("fs_after_release", frame_start, 1);
        if (phase_a) begin
            if (n >= 3 && n < 11) check_val("first8", pixel, first_pat[10 - n]);
            if (p >= 15 * HT + 56 && p < 15 * HT + 64) check_val("lastcell", pixel, 1);
            if (p == 15 * HT + 64) begin
                check_val("pix_after_de", pixel, 0);
                check_val("de_after_cell", de, 0);
            end
            if (n >= 3 && n < 3 + FT && de) de_cnt++;
            if (n >= 3 && n < 3 + HT && !hsync) hs_cnt++;
            if (frame_start && fs_seen < 2) begin fs_n[fs_seen] = n; fs_seen++; end
            if (de && !prev_de && rise_seen < 2) begin de_rise[rise_seen] = n; rise_seen++; end
            prev_de = de;
        end
        if (cursor_en && p >= 0 && (p % FT == 16 || p % FT == 7 * HT + 23))
            check_val("cursor", pixel, cur_exp[(p / FT) % 5]);
        @(negedge clk);
        n++;
    endtask

    initial begin
        for (int unsigned i = 0; i < 2048; i++) begin
            ram[i] = 8'h00;
            rom[i] = 8'h00;
        end
        ram[0]  = 8'h41;
        ram[1]  = 8'h42;
        ram[65] = 8'h41;
        ram[{5'd1, 6'd7}] = 8'hFF;
        rom[11'h208] = 8'hA5;
        for (int unsigned k = 1; k < 8; k++) rom[11'h208 + k] = 8'h3C ^ 8'(k);
        for (int unsigned k = 0; k < 8; k++) rom[11'h210 + k] = 8'h80 >> k;
        for (int unsigned k = 0; k < 8; k++) rom[11'h7F8 + k] = 8'hFF;

        reset = 1'b1;
        cursor_en = 1'b0;
        cursor_ad = '0;
        repeat (3) @(negedge clk);
        check_val("rst_de", de, 0);
        check_val("rst_pixel", pixel, 0);
        check_val("rst_fs", frame_start, 0);
        check_val("rst_hsync", hsync, 1);
        check_val("rst_vsync", vsync, 1);
        check_val("rst_read_ad", read_ad, 0);

        reset = 1'b0;
        n = 0;
        phase_a = 1'b1;
        repeat (FT + 8) tick();
        phase_a = 1'b0;
        check_val("fs_first", fs_n[0], 3);
        check_val("frame_period", fs_n[1] - fs_n[0], FT);
        check_val("line_period", de_rise[1] - de_rise[0], HT);
        check_val("de_per_frame", de_cnt, HA * VA);
        check_val("hsync_width", hs_cnt, HS);

        while (n % FT != 10 * HT + 30) tick();
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_de", de, 0);
        check_val("midrst_pixel", pixel, 0);
        check_val("midrst_fs", frame_start, 0);
        check_val("midrst_hsync", hsync, 1);
        check_val("midrst_vsync", vsync, 1);
        check_val("midrst_read_ad", read_ad, 0);
        check_val("midrst_font_ad", font_ad, 0);

        reset = 1'b0;
        n = 0;
        cursor_en = 1'b1;
        cursor_ad = 11'd2;
        repeat (5 * FT + 10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
